// File: rtl/riscv_writeback_if.sv
// Writeback bundle: ALU result handshake, load issue/response, regfile write port.
// master = writeback unit view; slave = surrounding pipeline/memory/regfile view.
interface riscv_writeback_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;
    logic              ld_issue;
    logic [REG_AW-1:0] ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_addr_lo;
    logic              ld_busy;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic [REG_AW-1:0] writeReg;
    logic [XLEN-1:0]   writeData;
    logic              write;
    logic              ld_err;
`ifdef WB_SCOREBOARD_EN
    logic [31:0]       busy_mask;
`endif

    modport master (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        input  mem_rvalid, mem_rdata,
        output alu_ready, ld_busy,
        output writeReg, writeData, write, ld_err
`ifdef WB_SCOREBOARD_EN
        , output busy_mask
`endif
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
        output mem_rvalid, mem_rdata,
        input  alu_ready, ld_busy,
        input  writeReg, writeData, write, ld_err
`ifdef WB_SCOREBOARD_EN
        , input busy_mask
`endif
    );
endinterface

// File: rtl/riscv_writeback.sv
// Register-file write master: merges ALU results and formatted load data into
// one registered write per cycle; a 1-entry skid buffer back-pressures the ALU.
// Ports: clk, rst (sync, active-high), wb (riscv_writeback_if.master):
//   alu_valid/alu_rd/alu_data/alu_ready  ALU result handshake
//   ld_issue/ld_rd/ld_funct3/ld_addr_lo/ld_busy  load issue
//   mem_rvalid/mem_rdata  load response; writeReg/writeData/write  regfile port
//   ld_err  sticky error flag
// Optional: define WB_SCOREBOARD_EN to add busy_mask (pending load targets).
module riscv_writeback #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    riscv_writeback_if.master  wb
);
    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_lo_q, ld_lo_d;

    logic              skid_full_q, skid_full_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;

    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic              ld_err_q, ld_err_d;

    logic              ld_hit;
    logic              alu_acc;
    logic [XLEN-1:0]   fmt_data;
    logic              fmt_err;
    logic [XLEN-1:0]   shifted;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    logic              win;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    assign ld_hit       = (state_q == WAIT) && wb.mem_rvalid;
    assign wb.alu_ready = ~skid_full_q;
    assign alu_acc      = wb.alu_valid && ~skid_full_q;
    assign wb.ld_busy   = (state_q == WAIT);
    assign wb.write     = wr_en_q;
    assign wb.writeReg  = wr_reg_q;
    assign wb.writeData = wr_data_q;
    assign wb.ld_err    = ld_err_q;

    // Load data formatting from the captured funct3 / address bits
    always_comb begin
        fmt_data = '0;
        fmt_err  = 1'b0;
        shifted  = wb.mem_rdata >> {ld_lo_q, 3'b000};
        byte_v   = shifted[7:0];
        half_v   = ld_lo_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
        case (ld_f3_q)
            3'b000: fmt_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100: fmt_data = {{(XLEN-8){1'b0}}, byte_v};
            3'b001: begin
                fmt_data = {{(XLEN-16){half_v[15]}}, half_v};
                fmt_err  = ld_lo_q[0];
            end
            3'b101: begin
                fmt_data = {{(XLEN-16){1'b0}}, half_v};
                fmt_err  = ld_lo_q[0];
            end
            3'b010: begin
                fmt_data = wb.mem_rdata;
                fmt_err  = (ld_lo_q != 2'b00);
            end
            default: begin
                fmt_data = '0;
                fmt_err  = 1'b1;
            end
        endcase
    end

    // Load FSM
    always_comb begin
        state_d = state_q;
        ld_rd_d = ld_rd_q;
        ld_f3_d = ld_f3_q;
        ld_lo_d = ld_lo_q;
        unique case (state_q)
            IDLE: begin
                if (wb.ld_issue) begin
                    ld_rd_d = wb.ld_rd;
                    ld_f3_d = wb.ld_funct3;
                    ld_lo_d = wb.ld_addr_lo;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wb.mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration: load result > skid entry > incoming ALU result
    always_comb begin
        skid_full_d = skid_full_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        win         = 1'b0;
        win_rd      = '0;
        win_data    = '0;
        if (ld_hit) begin
            win      = 1'b1;
            win_rd   = ld_rd_q;
            win_data = fmt_data;
            // alu_acc implies skid empty, so no entry is overwritten
            if (alu_acc) begin
                skid_full_d = 1'b1;
                skid_rd_d   = wb.alu_rd;
                skid_data_d = wb.alu_data;
            end
        end else if (skid_full_q) begin
            win         = 1'b1;
            win_rd      = skid_rd_q;
            win_data    = skid_data_q;
            skid_full_d = 1'b0;
        end else if (alu_acc) begin
            win      = 1'b1;
            win_rd   = wb.alu_rd;
            win_data = wb.alu_data;
        end
    end

    // Output stage and sticky error
    always_comb begin
        wr_en_d   = win && (win_rd != '0);
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (win) begin
            wr_reg_d  = win_rd;
            wr_data_d = win_data;
        end
        ld_err_d = ld_err_q
                 | ((state_q == IDLE) && wb.mem_rvalid)
                 | (ld_hit && fmt_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_rd_q     <= '0;
            ld_f3_q     <= '0;
            ld_lo_q     <= '0;
            skid_full_q <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            wr_en_q     <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_f3_q     <= ld_f3_d;
            ld_lo_q     <= ld_lo_d;
            skid_full_q <= skid_full_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            wr_en_q     <= wr_en_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            ld_err_q    <= ld_err_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_mask_q, busy_mask_d;

    // Set on load acceptance, cleared on the edge that writes the load back
    always_comb begin
        busy_mask_d = busy_mask_q;
        if ((state_q == IDLE) && wb.ld_issue && (wb.ld_rd != '0)) begin
            busy_mask_d[wb.ld_rd] = 1'b1;
        end
        if (ld_hit) begin
            busy_mask_d[ld_rd_q] = 1'b0;
        end
        busy_mask_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_q <= '0;
        end else begin
            busy_mask_q <= busy_mask_d;
        end
    end

    assign wb.busy_mask = busy_mask_q;
`endif
endmodule

// File: tb/tb_riscv_writeback.sv
// Directed self-checking bench for riscv_writeback.
// Inputs change 1ns after posedge; outputs are sampled at the same point.
module tb_riscv_writeback;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    riscv_writeback_if bus ();

    riscv_writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.ld_issue   = 1'b0;
        bus.ld_rd      = '0;
        bus.ld_funct3  = '0;
        bus.ld_addr_lo = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (bus.write !== 1'b0) begin n_bad++; $display("FAIL rst_write got %b want 0", bus.write); end
        n_cmp++; if (bus.writeReg !== 5'd0) begin n_bad++; $display("FAIL rst_writeReg got %0d want 0", bus.writeReg); end
        n_cmp++; if (bus.writeData !== 32'h0) begin n_bad++; $display("FAIL rst_writeData got %h want 0", bus.writeData); end
        n_cmp++; if (bus.ld_err !== 1'b0) begin n_bad++; $display("FAIL rst_ld_err got %b want 0", bus.ld_err); end
        n_cmp++; if (bus.ld_busy !== 1'b0) begin n_bad++; $display("FAIL rst_ld_busy got %b want 0", bus.ld_busy); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_alu_ready got %b want 1", bus.alu_ready); end
`ifdef WB_SCOREBOARD_EN
        n_cmp++; if (bus.busy_mask !== 32'h0) begin n_bad++; $display("FAIL rst_busy_mask got %h want 0", bus.busy_mask); end
`endif
    endtask

    task automatic test_alu_only();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'h0000_1234;
        step();
        bus.alu_valid = 1'b0;
        n_cmp++; if (bus.write !== 1'b1) begin n_bad++; $display("FAIL alu_write got %b want 1", bus.write); end
        n_cmp++; if (bus.writeReg !== 5'd5) begin n_bad++; $display("FAIL alu_writeReg got %0d want 5", bus.writeReg); end
        n_cmp++; if (bus.writeData !== 32'h1234) begin n_bad++; $display("FAIL alu_writeData got %h want 00001234", bus.writeData); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got %b want 1", bus.alu_ready); end
        step();
        n_cmp++; if (bus.write !== 1'b0) begin n_bad++; $display("FAIL alu_idle_write got %b want 0", bus.write); end
        n_cmp++; if (bus.writeData !== 32'h1234) begin n_bad++; $display("FAIL alu_hold_data got %h want 00001234", bus.writeData); end
    endtask

    // Issue at cycle 0, a spurious re-issue during WAIT, response at cycle 2
    task automatic test_load(input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] rdata, input logic [31:0] exp,
                             input logic [4:0] rd);
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = rd;
        bus.ld_funct3  = f3;
        bus.ld_addr_lo = lo;
        step();
        bus.ld_rd     = 5'd12;
        bus.ld_funct3 = 3'b010;
        n_cmp++; if (bus.ld_busy !== 1'b1) begin n_bad++; $display("FAIL ld_busy1 f3=%b got %b want 1", f3, bus.ld_busy); end
        step();
        bus.ld_issue = 1'b0;
        n_cmp++; if (bus.ld_busy !== 1'b1 || bus.write !== 1'b0) begin n_bad++; $display("FAIL ld_wait f3=%b busy=%b write=%b want 1/0", f3, bus.ld_busy, bus.write); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== rd) begin n_bad++; $display("FAIL ld_wr f3=%b got write=%b reg=%0d want 1/%0d", f3, bus.write, bus.writeReg, rd); end
        n_cmp++; if (bus.writeData !== exp) begin n_bad++; $display("FAIL ld_data f3=%b lo=%0d got %h want %h", f3, lo, bus.writeData, exp); end
        n_cmp++; if (bus.ld_busy !== 1'b0) begin n_bad++; $display("FAIL ld_busy_end f3=%b got %b want 0", f3, bus.ld_busy); end
    endtask

    task automatic test_load_format();
        test_load(3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 5'd7);
        test_load(3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080, 5'd7);
        test_load(3'b000, 2'd1, 32'h1234_5678, 32'h0000_0056, 5'd10);
        test_load(3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001, 5'd11);
        test_load(3'b101, 2'd2, 32'h8001_1234, 32'h0000_8001, 5'd13);
        test_load(3'b001, 2'd0, 32'h1234_F00D, 32'hFFFF_F00D, 5'd14);
        test_load(3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd15);
        n_cmp++; if (bus.ld_err !== 1'b0) begin n_bad++; $display("FAIL fmt_no_err got %b want 0", bus.ld_err); end
    endtask

    task automatic test_collision();
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = 5'd3;
        bus.ld_funct3  = 3'b010;
        bus.ld_addr_lo = 2'd0;
        step();
        bus.ld_issue   = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hAAAA_5555;
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd4;
        bus.alu_data   = 32'h11;
        step();
        bus.mem_rvalid = 1'b0;
        bus.alu_rd     = 5'd6;
        bus.alu_data   = 32'h66;
        n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== 5'd3 || bus.writeData !== 32'hAAAA_5555) begin n_bad++; $display("FAIL col_ld got %b/%0d/%h want 1/3/aaaa5555", bus.write, bus.writeReg, bus.writeData); end
        n_cmp++; if (bus.alu_ready !== 1'b0) begin n_bad++; $display("FAIL col_ready_lo got %b want 0", bus.alu_ready); end
        step();
        n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== 5'd4 || bus.writeData !== 32'h11) begin n_bad++; $display("FAIL col_skid got %b/%0d/%h want 1/4/00000011", bus.write, bus.writeReg, bus.writeData); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL col_ready_hi got %b want 1", bus.alu_ready); end
        step();
        bus.alu_valid = 1'b0;
        n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== 5'd6 || bus.writeData !== 32'h66) begin n_bad++; $display("FAIL col_r6 got %b/%0d/%h want 1/6/00000066", bus.write, bus.writeReg, bus.writeData); end
        step();
        n_cmp++; if (bus.write !== 1'b0) begin n_bad++; $display("FAIL col_no_dup got %b want 0", bus.write); end
    endtask

    task automatic test_back_to_back();
        bus.alu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.alu_rd   = 5'(i);
            bus.alu_data = 32'hA0 + 32'(i);
            step();
            n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== 5'(i) || bus.writeData !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL b2b_%0d got %b/%0d/%h", i, bus.write, bus.writeReg, bus.writeData); end
        end
        bus.alu_valid = 1'b0;
        // new load accepted in the cycle right after the response
        bus.ld_issue  = 1'b1;
        bus.ld_rd     = 5'd20;
        bus.ld_funct3 = 3'b010;
        step();
        bus.ld_issue   = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0001;
        step();
        bus.mem_rvalid = 1'b0;
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = 5'd21;
        step();
        bus.ld_issue = 1'b0;
        n_cmp++; if (bus.ld_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reissue busy got %b want 1", bus.ld_busy); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0002;
        step();
        bus.mem_rvalid = 1'b0;
        n_cmp++; if (bus.write !== 1'b1 || bus.writeReg !== 5'd21 || bus.writeData !== 32'h2) begin n_bad++; $display("FAIL b2b_ld2 got %b/%0d/%h want 1/21/00000002", bus.write, bus.writeReg, bus.writeData); end
    endtask

    task automatic test_x0_and_errors();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h55;
        step();
        bus.alu_valid = 1'b0;
        n_cmp++; if (bus.write !== 1'b0) begin n_bad++; $display("FAIL x0_write got %b want 0", bus.write); end
        n_cmp++; if (bus.writeReg !== 5'd0 || bus.writeData !== 32'h55) begin n_bad++; $display("FAIL x0_update got %0d/%h want 0/00000055", bus.writeReg, bus.writeData); end
        test_load(3'b001, 2'd1, 32'h1234_5678, 32'h0000_5678, 5'd8);
        n_cmp++; if (bus.ld_err !== 1'b1) begin n_bad++; $display("FAIL lh_misalign_err got %b want 1", bus.ld_err); end
        test_load(3'b011, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 5'd9);
        n_cmp++; if (bus.ld_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", bus.ld_err); end
    endtask

    task automatic test_lw_misalign();
        rst = 1'b1;
        step();
        rst = 1'b0;
        test_load(3'b010, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 5'd16);
        n_cmp++; if (bus.ld_err !== 1'b1) begin n_bad++; $display("FAIL lw_misalign_err got %b want 1", bus.ld_err); end
    endtask

    task automatic test_reset_mid_load();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ld_issue  = 1'b1;
        bus.ld_rd     = 5'd17;
        bus.ld_funct3 = 3'b010;
        step();
        bus.ld_issue = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.ld_busy !== 1'b0 || bus.ld_err !== 1'b0) begin n_bad++; $display("FAIL midrst_state busy=%b err=%b want 0/0", bus.ld_busy, bus.ld_err); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
        step();
        bus.mem_rvalid = 1'b0;
        n_cmp++; if (bus.write !== 1'b0) begin n_bad++; $display("FAIL midrst_write got %b want 0", bus.write); end
        n_cmp++; if (bus.ld_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.ld_busy); end
        n_cmp++; if (bus.ld_err !== 1'b1) begin n_bad++; $display("FAIL midrst_err got %b want 1", bus.ld_err); end
    endtask

`ifdef WB_SCOREBOARD_EN
    task automatic test_scoreboard();
        bus.ld_issue   = 1'b1;
        bus.ld_rd      = 5'd9;
        bus.ld_funct3  = 3'b010;
        bus.ld_addr_lo = 2'd0;
        step();
        bus.ld_issue = 1'b0;
        n_cmp++; if (bus.busy_mask !== 32'h0000_0200) begin n_bad++; $display("FAIL sb_set got %h want 00000200", bus.busy_mask); end
        step();
        n_cmp++; if (bus.busy_mask !== 32'h0000_0200) begin n_bad++; $display("FAIL sb_hold got %h want 00000200", bus.busy_mask); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h9;
        step();
        bus.mem_rvalid = 1'b0;
        n_cmp++; if (bus.busy_mask !== 32'h0 || bus.write !== 1'b1) begin n_bad++; $display("FAIL sb_clear got %h/%b want 0/1", bus.busy_mask, bus.write); end
        bus.ld_issue = 1'b1;
        bus.ld_rd    = 5'd0;
        step();
        bus.ld_issue = 1'b0;
        n_cmp++; if (bus.busy_mask !== 32'h0) begin n_bad++; $display("FAIL sb_x0 got %h want 0", bus.busy_mask); end
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_only();
        test_load_format();
        test_collision();
        test_back_to_back();
`ifdef WB_SCOREBOARD_EN
        test_scoreboard();
`endif
        test_x0_and_errors();
        test_lw_misalign();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
